// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared definitions for the instruction/data memory arbiter:
//             FSM state encoding, grant identifiers and timer width.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    // Grant identifiers, also the encoding of the round-robin history bit
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    // Wait counter width, wide enough for the largest legal TIMEOUT (65535)
    localparam int TMR_W = 16;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Purpose  : Memory-side bus between the arbiter and the memory.
//  Ports    : m_req/m_we/m_addr/m_wdata driven by the arbiter (master),
//             m_rdata/m_ready driven by the memory (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ready;

    modport master (
        output m_req, m_we, m_addr, m_wdata,
        input  m_rdata, m_ready
    );

    modport slave (
        input  m_req, m_we, m_addr, m_wdata,
        output m_rdata, m_ready
    );
endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/mem_arb_timer.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_timer
//  Purpose  : Wait counter for an outstanding memory transaction with a
//             terminal-count compare.
//  Ports    : clk, reset (async, active-high)
//             clr     - clear the count (on grant)
//             en      - count one waiting cycle
//             expired - count has reached TIMEOUT-1, so one more waiting
//                       cycle reaches TIMEOUT
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clr,
    input  wire logic en,
    output logic      expired
);

    logic [TMR_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + TMR_W'(1);
        end
    end

    // Flagged one cycle early so the abort decision and the final wait cycle
    // coincide; the transaction is aborted before the count could wrap.
    assign expired = (r_count == TMR_W'(TIMEOUT - 1));

endmodule : mem_arb_timer
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Arbitrates an instruction-fetch port and a data port onto a
//             single memory bus, one transaction at a time, with a wait
//             timeout that aborts a stalled transaction.
//  Ports    : clk, reset (async, active-high)
//             i_req/i_addr/i_rdata/i_ack                  - fetch port
//             d_req/d_we/d_addr/d_wdata/d_rdata/d_ack     - data port
//             mem (mem_arbiter_if.master)                 - memory bus
//             bus_err - pulses with the ack of a timed-out transaction
//  Config   : ARB_ROUND_ROBIN_EN - when defined, simultaneous requests
//             alternate between ports; otherwise data always wins.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  wire logic          clk,
    input  wire logic          reset,

    input  wire logic          i_req,
    input  wire logic [AW-1:0] i_addr,
    output logic      [DW-1:0] i_rdata,
    output logic               i_ack,

    input  wire logic          d_req,
    input  wire logic          d_we,
    input  wire logic [AW-1:0] d_addr,
    input  wire logic [DW-1:0] d_wdata,
    output logic      [DW-1:0] d_rdata,
    output logic               d_ack,

    output logic               bus_err,

    mem_arbiter_if.master      mem
);

    state_t        r_state, w_state_nxt;
    logic          r_m_req, w_m_req_nxt;
    logic          r_m_we, w_m_we_nxt;
    logic [AW-1:0] r_m_addr, w_m_addr_nxt;
    logic [DW-1:0] r_m_wdata, w_m_wdata_nxt;
    logic [DW-1:0] r_i_rdata, w_i_rdata_nxt;
    logic [DW-1:0] r_d_rdata, w_d_rdata_nxt;
    logic          r_i_ack, w_i_ack_nxt;
    logic          r_d_ack, w_d_ack_nxt;
    logic          r_bus_err, w_bus_err_nxt;

    logic          w_grant_d;
    logic          w_tmr_clr;
    logic          w_tmr_en;
    logic          w_tmr_expired;

    // ------------------------------------------------------------------
    // Arbitration between the two ports while idle
    // ------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_grant;

    // Every grant (contested or not) updates the history bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= GNT_D;
        end else if (r_state == IDLE && (i_req || d_req)) begin
            r_last_grant <= w_grant_d ? GNT_D : GNT_I;
        end
    end

    assign w_grant_d = d_req && (!i_req || (r_last_grant == GNT_I));
`else
    assign w_grant_d = d_req;
`endif

    // ------------------------------------------------------------------
    // Wait timer
    // ------------------------------------------------------------------
    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (w_tmr_clr),
        .en      (w_tmr_en),
        .expired (w_tmr_expired)
    );

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_m_req   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_m_req   <= w_m_req_nxt;
            r_m_we    <= w_m_we_nxt;
            r_m_addr  <= w_m_addr_nxt;
            r_m_wdata <= w_m_wdata_nxt;
            r_i_rdata <= w_i_rdata_nxt;
            r_d_rdata <= w_d_rdata_nxt;
            r_i_ack   <= w_i_ack_nxt;
            r_d_ack   <= w_d_ack_nxt;
            r_bus_err <= w_bus_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_m_req_nxt   = r_m_req;
        w_m_we_nxt    = r_m_we;
        w_m_addr_nxt  = r_m_addr;
        w_m_wdata_nxt = r_m_wdata;
        w_i_rdata_nxt = r_i_rdata;
        w_d_rdata_nxt = r_d_rdata;
        w_i_ack_nxt   = 1'b0;
        w_d_ack_nxt   = 1'b0;
        w_bus_err_nxt = 1'b0;
        w_tmr_clr     = 1'b0;
        w_tmr_en      = 1'b0;

        case (r_state)
            IDLE: begin
                // The memory bus is only updated here, so it stays stable
                // for the whole transaction whatever the requesters do.
                if (w_grant_d) begin
                    w_state_nxt   = D_BUSY;
                    w_m_req_nxt   = 1'b1;
                    w_m_we_nxt    = d_we;
                    w_m_addr_nxt  = d_addr;
                    w_m_wdata_nxt = d_wdata;
                    w_tmr_clr     = 1'b1;
                end else if (i_req) begin
                    w_state_nxt   = I_BUSY;
                    w_m_req_nxt   = 1'b1;
                    w_m_we_nxt    = 1'b0;
                    w_m_addr_nxt  = i_addr;
                    w_m_wdata_nxt = '0;
                    w_tmr_clr     = 1'b1;
                end
            end

            I_BUSY: begin
                w_tmr_en = !mem.m_ready;
                if (mem.m_ready) begin
                    w_i_rdata_nxt = mem.m_rdata;
                    w_i_ack_nxt   = 1'b1;
                    w_m_req_nxt   = 1'b0;
                    w_state_nxt   = IDLE;
                end else if (w_tmr_expired) begin
                    w_i_rdata_nxt = '0;
                    w_i_ack_nxt   = 1'b1;
                    w_bus_err_nxt = 1'b1;
                    w_m_req_nxt   = 1'b0;
                    w_state_nxt   = IDLE;
                end
            end

            D_BUSY: begin
                w_tmr_en = !mem.m_ready;
                if (mem.m_ready) begin
                    // Stores leave the load-data register untouched
                    if (!r_m_we) begin
                        w_d_rdata_nxt = mem.m_rdata;
                    end
                    w_d_ack_nxt   = 1'b1;
                    w_m_req_nxt   = 1'b0;
                    w_state_nxt   = IDLE;
                end else if (w_tmr_expired) begin
                    w_d_rdata_nxt = '0;
                    w_d_ack_nxt   = 1'b1;
                    w_bus_err_nxt = 1'b1;
                    w_m_req_nxt   = 1'b0;
                    w_state_nxt   = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_m_req_nxt = 1'b0;
            end
        endcase
    end

    assign mem.m_req   = r_m_req;
    assign mem.m_we    = r_m_we;
    assign mem.m_addr  = r_m_addr;
    assign mem.m_wdata = r_m_wdata;

    assign i_rdata = r_i_rdata;
    assign i_ack   = r_i_ack;
    assign d_rdata = r_d_rdata;
    assign d_ack   = r_d_ack;
    assign bus_err = r_bus_err;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter (TIMEOUT = 4) with a
//             delay-programmable memory model and an expected-result queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, i_rdata, d_rdata;
    logic          i_ack, d_ack, bus_err;

    mem_arbiter_if #(.DW(DW), .AW(AW)) mem ();

    mem_arbiter #(
        .DW      (DW),
        .AW      (AW),
        .TIMEOUT (TO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ack   (i_ack),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ack   (d_ack),
        .bus_err (bus_err),
        .mem     (mem)
    );

    always #5 clk = ~clk;

    // Memory model: answers after mem_delay cycles of m_req, or at once when
    // force_ready ties m_ready high.
    int            mem_delay;
    logic [DW-1:0] mem_data;
    logic          force_ready;
    int            busy_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset)            busy_cnt <= 0;
        else if (mem.m_req)   busy_cnt <= busy_cnt + 1;
        else                  busy_cnt <= 0;
    end

    assign mem.m_ready = force_ready | (mem.m_req && (busy_cnt >= mem_delay));
    assign mem.m_rdata = mem_data;

    typedef struct {
        logic          is_d;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] mdata;
        int            delay;
        logic          exp_err;
        int            exp_busy;
    } vec_t;

    typedef struct {
        logic          is_d;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] mdl_i_rdata, mdl_d_rdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        mdl_i_rdata = '0;
        mdl_d_rdata = '0;
    endtask

    // One single-port transaction: drive, push the expectation, watch the
    // bus every cycle, pop and compare on the ack.
    task automatic run_vec(input vec_t v);
        exp_t e;
        int   busy;
        bit   done;
        @(negedge clk);
        mem_delay = v.delay;
        mem_data  = v.mdata;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        e.is_d = v.is_d;
        e.err  = v.exp_err;
        if (v.exp_err)            e.rdata = '0;
        else if (v.is_d && v.we)  e.rdata = mdl_d_rdata;
        else                      e.rdata = v.mdata;
        sb.push_back(e);

        busy = 0;
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (mem.m_req) begin
                busy++;
                check("m_addr", mem.m_addr, v.addr);
                check("m_we", mem.m_we, v.is_d & v.we);
                check("m_wdata", mem.m_wdata, v.is_d ? v.wdata : '0);
                // wiggle requester inputs; the bus must not follow them
                i_addr  = $urandom;
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_we    = 1'($urandom);
            end
            if (i_ack || d_ack) done = 1'b1;
        end

        e = sb.pop_front();
        if (!done) begin
            check("ack_wait_bound", 0, 1);
        end else begin
            check("ack_port", {i_ack, d_ack}, e.is_d ? 2'b01 : 2'b10);
            check("rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
            check("other_rdata", e.is_d ? i_rdata : d_rdata, e.is_d ? mdl_i_rdata : mdl_d_rdata);
            check("bus_err", bus_err, e.err);
            check("m_req_drop", mem.m_req, 0);
            check("busy_cycles", busy, v.exp_busy);
            if (e.is_d) mdl_d_rdata = e.rdata;
            else        mdl_i_rdata = e.rdata;
        end
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        check("ack_one_cycle", {i_ack, d_ack, bus_err}, 3'b000);
    endtask

    vec_t vt[8];

    initial begin
        int   order[3];
        int   n_ack;
        int   pulses;
        logic stray;

        vt[0] = '{1'b0, 1'b0, 32'h44,  32'h0,        32'h12345678, 0,   1'b0, 1};
        vt[1] = '{1'b1, 1'b0, 32'h20,  32'h0,        32'hCAFEF00D, 1,   1'b0, 2};
        vt[2] = '{1'b1, 1'b1, 32'h400, 32'hDEADBEEF, 32'h11111111, 3,   1'b0, 4};
        vt[3] = '{1'b0, 1'b0, 32'h48,  32'h0,        32'h0BADC0DE, 2,   1'b0, 3};
        vt[4] = '{1'b1, 1'b0, 32'h80,  32'h0,        32'h00000099, 100, 1'b1, TO};
        vt[5] = '{1'b1, 1'b0, 32'h84,  32'h0,        32'h55AA55AA, 0,   1'b0, 1};
        vt[6] = '{1'b1, 1'b1, 32'h500, 32'h01020304, 32'h00000077, 100, 1'b1, TO};
        vt[7] = '{1'b0, 1'b0, 32'h90,  32'h0,        32'h00000005, 100, 1'b1, TO};

        reset = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        force_ready = 1'b0; mem_delay = 0; mem_data = '0;
        mdl_i_rdata = '0; mdl_d_rdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_m_req", mem.m_req, 0);
        check("rst_m_we", mem.m_we, 0);
        check("rst_m_addr", mem.m_addr, 0);
        check("rst_m_wdata", mem.m_wdata, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_acks", {i_ack, d_ack, bus_err}, 0);

        // m_ready with no request pending is ignored
        force_ready = 1'b1;
        stray = 1'b0;
        repeat (4) begin
            @(negedge clk);
            stray |= mem.m_req | i_ack | d_ack | bus_err;
        end
        check("idle_ready_ignored", stray, 0);

        // Minimum-latency fetch with m_ready tied high
        mem_data = 32'h13;
        i_req = 1'b1; i_addr = 32'h10;
        @(negedge clk);
        check("fetch_m_req", mem.m_req, 1);
        check("fetch_m_addr", mem.m_addr, 32'h10);
        check("fetch_early_ack", i_ack, 0);
        @(negedge clk);
        check("fetch_i_ack", i_ack, 1);
        check("fetch_i_rdata", i_rdata, 32'h13);
        check("fetch_m_req_drop", mem.m_req, 0);
        i_req = 1'b0;
        mdl_i_rdata = 32'h13;
        force_ready = 1'b0;

        // Table-driven transactions
        for (int k = 0; k < 8; k++) run_vec(vt[k]);

        // Both ports held high across three transactions
        do_reset();
        @(negedge clk);
        mem_delay = 0; mem_data = 32'h77;
        d_we = 1'b0; d_addr = 32'h600; i_addr = 32'h700;
        i_req = 1'b1; d_req = 1'b1;
        n_ack = 0;
        for (int c = 0; c < 40 && n_ack < 3; c++) begin
            @(negedge clk);
            if (i_ack || d_ack) begin
                check("both_single_ack", i_ack & d_ack, 0);
                check("both_rdata", d_ack ? d_rdata : i_rdata, 32'h77);
                order[n_ack] = d_ack ? 1 : 0;
                n_ack++;
                if (n_ack == 3) begin
                    i_req = 1'b0; d_req = 1'b0;
                end
            end
        end
        check("both_ack_count", n_ack, 3);
        if (n_ack == 3) begin
`ifdef ARB_ROUND_ROBIN_EN
            check("order_0", order[0], 0);
            check("order_1", order[1], 1);
            check("order_2", order[2], 0);
            mdl_i_rdata = 32'h77;
`else
            check("order_0", order[0], 1);
            check("order_1", order[1], 1);
            check("order_2", order[2], 1);
`endif
        end
        i_req = 1'b0; d_req = 1'b0;
        mdl_d_rdata = 32'h77;
        @(negedge clk);

        // Reset two cycles into a stalled load
        @(negedge clk);
        mem_delay = 100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_m_req", mem.m_req, 0);
        check("rst_mid_acks", {d_ack, bus_err}, 0);
        d_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        mdl_i_rdata = '0; mdl_d_rdata = '0;
        stray = 1'b0;
        repeat (6) begin
            @(negedge clk);
            stray |= mem.m_req | i_ack | d_ack | bus_err;
        end
        check("rst_mid_quiet", stray, 0);
        run_vec('{1'b1, 1'b0, 32'h204, 32'h0, 32'h31415926, 1, 1'b0, 2});

        // Request dropped right after grant still completes once
        @(negedge clk);
        mem_delay = 2; mem_data = 32'hABCD1234;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        @(negedge clk);
        check("drop_granted", mem.m_req, 1);
        d_req = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (d_ack) begin
                pulses++;
                check("drop_rdata", d_rdata, 32'hABCD1234);
            end
        end
        check("drop_ack_pulses", pulses, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DW, default 32, data width of all data buses.
REQ-002 Parameter AW, default 32, address width of all address buses.
REQ-003 Parameter TIMEOUT, default 255, max cycles waiting for m_ready before abort; legal range 1..65535.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 i_req  input  1  instruction-fetch request, held until i_ack.
REQ-007 i_addr  input  AW  fetch address.
REQ-008 i_rdata  output  DW  fetched word, valid in i_ack cycle.
REQ-009 i_ack  output  1  one-cycle fetch completion pulse.
REQ-010 d_req  input  1  data request, held until d_ack.
REQ-011 d_we  input  1  1 = store, 0 = load.
REQ-012 d_addr  input  AW  data address.
REQ-013 d_wdata  input  DW  store data.
REQ-014 d_rdata  output  DW  load data, valid in d_ack cycle.
REQ-015 d_ack  output  1  one-cycle data completion pulse.
REQ-016 m_req  output  1  memory request.
REQ-017 m_we  output  1  memory write enable.
REQ-018 m_addr  output  AW  memory address.
REQ-019 m_wdata  output  DW  memory write data.
REQ-020 m_rdata  input  DW  memory read data, valid with m_ready.
REQ-021 m_ready  input  1  memory completion, sampled only while m_req=1.
REQ-022 bus_err  output  1  one-cycle pulse, coincident with the ack of a timed-out transaction.

Function
REQ-023 FSM states: IDLE, I_BUSY, D_BUSY; all m_* outputs and ack/err outputs are registered.
REQ-024 IDLE: only i_req -> I_BUSY; only d_req -> D_BUSY; both -> policy per REQ-037/038; none -> stay in IDLE.
REQ-025 On grant, the requester's addr, we and wdata are latched; m_req=1 from the next cycle; fetches drive m_we=0 and m_wdata=0.
REQ-026 m_addr, m_we and m_wdata are held stable while m_req=1, regardless of requester inputs.
REQ-027 BUSY with m_ready=1: m_rdata is captured into the granted rdata output, the granted ack pulses next cycle, m_req drops, and the FSM returns to IDLE.
REQ-028 Minimum latency from req high in IDLE to ack: 2 cycles with m_ready tied high; every transaction is followed by at least one IDLE cycle.
REQ-029 i_rdata and d_rdata hold their last captured value until overwritten; for stores, d_rdata is unchanged.
REQ-030 A wait counter clears on grant and increments each BUSY cycle without m_ready; reaching TIMEOUT aborts the transaction.
REQ-031 On abort: ack and bus_err pulse together, the granted rdata is set to 0, m_req drops, and the FSM returns to IDLE.
REQ-032 A req deasserted mid-transaction does not cancel it; the transaction completes and the ack is still issued.
REQ-033 A req still high in the ack cycle is treated as a new request in the following IDLE cycle.
REQ-034 m_ready while m_req=0 is ignored.

Reset
REQ-035 Reset forces IDLE; m_req, m_we, i_ack, d_ack and bus_err go to 0; m_addr, m_wdata, i_rdata and d_rdata go to 0; the wait counter goes to 0; last_grant goes to data.
REQ-036 Reset mid-transaction abandons it with no ack and no bus_err.

Configuration
REQ-037 With ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the requester not in last_grant; last_grant updates on every grant.
REQ-038 Without ARB_ROUND_ROBIN_EN: fixed priority, data over fetch; last_grant is not implemented.

Structure
REQ-039 Package mem_arb_pkg holds the state encoding (IDLE=2'd0, I_BUSY=2'd1, D_BUSY=2'd2) and grant IDs (GNT_I=1'b0, GNT_D=1'b1).
REQ-040 The wait counter with terminal-count compare is a sub-module, mem_arb_timer, parameterised by TIMEOUT, with inputs clr and en and output expired.

Verification
REQ-041 i_req=1, i_addr=0x10, m_ready tied 1, m_rdata=0x00000013 -> m_req=1 with m_addr=0x10 one cycle after request; i_ack=1 and i_rdata=0x13 two cycles after request.
REQ-042 d_req=1, d_we=1, d_addr=0x400, d_wdata=0xDEADBEEF, m_ready delayed 3 cycles -> m_we=1, m_wdata=0xDEADBEEF held 4 cycles; then single d_ack; d_rdata unchanged.
REQ-043 i_req and d_req both high, held through 3 transactions -> grant order I, D, I with ARB_ROUND_ROBIN_EN; D, D, D without it.
REQ-044 TIMEOUT=4, m_ready held 0 -> after 4 BUSY cycles, d_ack=1, bus_err=1, d_rdata=0, FSM back in IDLE.
REQ-045 Reset asserted 2 cycles into a transaction -> m_req=0 immediately, no ack, IDLE afterward; a new request completes normally.
REQ-046 d_req dropped 1 cycle after grant -> transaction completes and d_ack still pulses once.
